// File: rtl/cordic_scheduler_pkg.sv
// cordic_scheduler_pkg: shared FSM type, requester count, data width and default watchdog limit
package cordic_scheduler_pkg;
    localparam int NREQ = 2;
    localparam int DW = 32;
    localparam int DEF_TIMEOUT = 64;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/cordic_scheduler_arb.sv
// rr_arbiter2: two-way round-robin grant, pointer remembers the last requester served
module rr_arbiter2
    import cordic_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            ack,
    output logic [NREQ-1:0] gnt
);
    logic last_q, last_d;
    always_comb begin
        gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
        last_d = ack ? gnt[1] : last_q;
    end
    // last_q resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk) last_q <= reset ? 1'b1 : last_d;
endmodule

// File: rtl/cordic_scheduler.sv
// cordic_scheduler: shares one CORDIC engine between two requesters with a watchdog on the engine wait
module cordic_scheduler
    import cordic_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*DW-1:0]   req_angle,
    input  logic [NREQ-1:0]   req_cos,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_err,
    output logic              eng_start,
    output logic [DW-1:0]     eng_dataa,
    output logic              eng_cos,
    input  logic              eng_done,
    input  logic [DW-1:0]     eng_result
);
    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            cos_q, cos_d;
    logic            err_q, err_d;
    logic [DW-1:0]   angle_q, angle_d;
    logic [DW-1:0]   data_q, data_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt;
    logic            hs;

    rr_arbiter2 u_arb (.clk(clk), .reset(reset), .req(req_valid), .ack(hs), .gnt(gnt));

    assign req_ready = (state_q == S_IDLE && !reset) ? gnt : '0;
    assign hs = |(req_valid & req_ready);
    assign eng_start = state_q == S_ISSUE;
    assign eng_dataa = angle_q;
    assign eng_cos = cos_q;
    assign rsp_valid = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data = data_q;
    assign rsp_err = state_q == S_RESP && err_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        angle_d = angle_q;
        cos_d = cos_q;
        data_d = data_q;
        err_d = err_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: if (hs) begin
                state_d = S_ISSUE;
                owner_d = gnt[1];
                angle_d = gnt[1] ? req_angle[2*DW-1:DW] : req_angle[DW-1:0];
                cos_d = req_cos[gnt[1]];
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // a done strobe in the final watchdog cycle still wins
                if (eng_done) begin
                    state_d = S_RESP;
                    data_d = eng_result;
                    err_d = 1'b0;
                end else if (cnt_d == 8'(TIMEOUT_CYC)) begin
                    state_d = S_RESP;
                    data_d = '0;
                    err_d = 1'b1;
                end
            end
            S_RESP: if (rsp_ready[owner_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            angle_q <= '0;
            cos_q <= 1'b0;
            data_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            angle_q <= angle_d;
            cos_q <= cos_d;
            data_q <= data_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cordic_scheduler.sv
// tb_cordic_scheduler: directed and random checks of the scheduler against a round-robin/latency reference
module tb_cordic_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0, req_cos = '0, rsp_ready = '0;
    logic [63:0] req_angle = '0;
    logic        eng_done = 1'b0;
    logic [31:0] eng_result = '0;
    logic [1:0]  req_ready, rsp_valid, req_ready8, rsp_valid8;
    logic [31:0] rsp_data, eng_dataa, rsp_data8, eng_dataa8;
    logic        rsp_err, eng_start, eng_cos, rsp_err8, eng_start8, eng_cos8;
    int          ncmp = 0, nerr = 0;
    int          last = 1;

    always #5 clk = ~clk;

    cordic_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_angle(req_angle), .req_cos(req_cos), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_start(eng_start), .eng_dataa(eng_dataa),
        .eng_cos(eng_cos), .eng_done(eng_done), .eng_result(eng_result)
    );

    cordic_scheduler #(.TIMEOUT_CYC(8)) dut8 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready8),
        .req_angle(req_angle), .req_cos(req_cos), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data8), .rsp_err(rsp_err8), .eng_start(eng_start8), .eng_dataa(eng_dataa8),
        .eng_cos(eng_cos8), .eng_done(eng_done), .eng_result(eng_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = 2'b11;
        step;
        step;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_eng_dataa", eng_dataa, 32'd0);
        chk("rst_eng_cos", 32'(eng_cos), 32'd0);
        reset = 1'b0;
        req_valid = '0;
        last = 1;
    endtask

    // one full transaction: reference picks winner, engine answers after lat cycles, owner holds off bp cycles
    task automatic op(input logic [1:0] vm, input int lat, input int bp, input logic [31:0] r);
        int w;
        logic [31:0] a;
        logic c;
        logic [1:0] own, other;
        w = (vm == 2'b11) ? 1 - last : (vm[1] ? 1 : 0);
        own = w != 0 ? 2'b10 : 2'b01;
        other = ~own;
        a = w != 0 ? req_angle[63:32] : req_angle[31:0];
        c = req_cos[w];
        req_valid = vm;
        #1;
        chk("grant", 32'(req_ready), 32'(own));
        step;
        req_valid = '0;
        chk("issue_start", 32'(eng_start), 32'd1);
        chk("issue_angle", eng_dataa, a);
        chk("issue_cos", 32'(eng_cos), 32'(c));
        chk("issue_ready", 32'(req_ready), 32'd0);
        for (int k = 1; k <= lat; k++) begin
            step;
            chk("wait_start", 32'(eng_start), 32'd0);
            chk("wait_valid", 32'(rsp_valid), 32'd0);
            chk("wait_angle", eng_dataa, a);
            if (k == lat) begin
                eng_done = 1'b1;
                eng_result = r;
            end
        end
        step;
        eng_done = 1'b0;
        eng_result = $urandom;
        chk("rsp_valid", 32'(rsp_valid), 32'(own));
        chk("rsp_data", rsp_data, r);
        chk("rsp_err", 32'(rsp_err), 32'd0);
        for (int k = 0; k < bp; k++) begin
            rsp_ready = other;
            req_valid = 2'($urandom_range(0, 3));
            step;
            chk("bp_valid", 32'(rsp_valid), 32'(own));
            chk("bp_data", rsp_data, r);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        rsp_ready = own | (other & 2'($urandom_range(0, 3)));
        step;
        rsp_ready = '0;
        chk("done_valid", 32'(rsp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd0);
        last = w;
    endtask

    initial begin
        do_reset;

        req_angle = {32'h0, 32'h2000_0000};
        req_cos = 2'b01;
        op(2'b01, 20, 0, 32'h1234_5678);

        do_reset;
        for (int i = 0; i < 4; i++) begin
            req_angle = {$urandom, $urandom};
            req_cos = 2'($urandom_range(0, 3));
            op(2'b11, $urandom_range(1, 10), 0, $urandom);
        end

        req_angle = {$urandom, $urandom};
        op(2'b01, 5, 10, $urandom);

        do_reset;
        req_angle = {$urandom, $urandom};
        req_valid = 2'b01;
        #1;
        chk("to_grant", 32'(req_ready8), 32'd1);
        step;
        req_valid = '0;
        chk("to_start", 32'(eng_start8), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            step;
            chk("to_wait8", 32'(rsp_valid8), 32'd0);
        end
        step;
        chk("to_valid8", 32'(rsp_valid8), 32'd1);
        chk("to_data8", rsp_data8, 32'd0);
        chk("to_err8", 32'(rsp_err8), 32'd1);
        for (int k = 10; k <= 64; k++) begin
            step;
            chk("to_wait64", 32'(rsp_valid), 32'd0);
        end
        step;
        chk("to_valid64", 32'(rsp_valid), 32'd1);
        chk("to_data64", rsp_data, 32'd0);
        chk("to_err64", 32'(rsp_err), 32'd1);
        eng_done = 1'b1;
        eng_result = 32'hFFFF_FFFF;
        step;
        eng_done = 1'b0;
        chk("late_valid8", 32'(rsp_valid8), 32'd1);
        chk("late_data8", rsp_data8, 32'd0);
        chk("late_err8", 32'(rsp_err8), 32'd1);
        chk("late_data64", rsp_data, 32'd0);
        chk("late_err64", 32'(rsp_err), 32'd1);
        rsp_ready = 2'b01;
        step;
        rsp_ready = '0;
        chk("to_release", 32'(rsp_valid), 32'd0);
        chk("to_release8", 32'(rsp_valid8), 32'd0);
        last = 0;

        req_angle = {$urandom, $urandom};
        req_valid = 2'b10;
        step;
        req_valid = '0;
        step;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        last = 1;
        eng_done = 1'b1;
        eng_result = $urandom;
        chk("rw_angle", eng_dataa, 32'd0);
        chk("rw_valid", 32'(rsp_valid), 32'd0);
        step;
        eng_done = 1'b0;
        chk("rw_ignored", 32'(rsp_valid), 32'd0);
        chk("rw_idle", 32'(req_ready), 32'd0);
        step;
        chk("rw_ignored2", 32'(rsp_valid), 32'd0);
        req_angle = {$urandom, $urandom};
        op(2'b11, 7, 1, $urandom);

        req_angle = {$urandom, $urandom};
        op(2'b01, 64, 0, $urandom);

        for (int i = 0; i < 25; i++) begin
            req_angle = {$urandom, $urandom};
            req_cos = 2'($urandom_range(0, 3));
            op(2'($urandom_range(1, 3)), $urandom_range(1, 30), $urandom_range(0, 4), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
